frame_buffer_manager: RTL
=========================

Name: frame_buffer_manager

Overview:
Triple-buffer scheduler for the DDR frame store shared by the camera-side AXI writer and the HDMI-side AXI reader. It assigns each side a frame base address and swaps buffers only at frame boundaries, so the reader never displays a partially written frame (no tearing). It also issues the per-frame restart pulse that the reader uses to clear its address offset. It runs in the clk_100Mhz (AXI) domain and synchronizes the display VSYNC coming from the 25 MHz pixel domain.

Parameters:
ADDR_WIDTH, 32, width of the base address outputs
BASE_ADDR, 32'h0100_0000, DDR address of buffer 0
FRAME_STRIDE, 32'h0004_0000, byte distance between buffers (covers one 320x240x16 bit frame of 0x25800 bytes)
CNT_WIDTH, 16, width of the status counters

Ports:
clk_100Mhz  in  1  AXI/system clock
rst  in  1  synchronous active-high reset
wr_frame_start  in  1  pulse: writer begins a frame
wr_frame_done  in  1  pulse: writer finished its last burst of the frame
wr_base_addr  out  ADDR_WIDTH  base address the writer must use
wr_active  out  1  writer FSM is in W_ACTIVE
rd_vsync_async  in  1  VSYNC level from the 25 MHz VTG domain (asynchronous)
rd_frame_done  out  1  1-cycle pulse to the reader: restart at rd_base_addr
rd_base_addr  out  ADDR_WIDTH  base address the reader must use
drop_cnt  out  CNT_WIDTH  completed frames overwritten before being displayed (saturating)
repeat_cnt  out  CNT_WIDTH  VSYNCs with no new frame available (saturating)

Behaviour:
Reset (all outputs registered):
- Index registers: wr_idx=0, rd_idx=1, rdy_idx=2, rdy_valid=0.
- wr_base_addr=BASE_ADDR; rd_base_addr=BASE_ADDR+FRAME_STRIDE.
- rd_frame_done=0, drop_cnt=0, repeat_cnt=0, FSM=W_IDLE.

Address rule:
- base = BASE_ADDR + idx*FRAME_STRIDE, selected by a 3-way mux of constants and truncated to ADDR_WIDTH.
- The index registers and address outputs update in the same cycle.

Writer FSM:
- W_IDLE -> W_ACTIVE on wr_frame_start.
- W_ACTIVE -> W_IDLE on wr_frame_done; this performs the write swap.
- wr_frame_start while in W_ACTIVE is ignored.
- wr_frame_done while in W_IDLE is ignored (no swap).

Write swap (wr_frame_done accepted):
- rdy_idx <= wr_idx, rdy_valid <= 1.
- wr_idx <= old rdy_idx. With three buffers this is always the buffer that is neither the reader's nor the one just completed.
- If rdy_valid was already 1, drop_cnt increments.
- wr_base_addr is valid from the cycle after wr_frame_done, before the next wr_frame_start.

VSYNC synchronizer:
- Two flops plus a previous-value flop; all three reset to 1, so a VSYNC held high across reset produces no spurious edge.
- A rising edge is detected on the synchronized signal. An async rise before clock edge k yields the read swap at edge k+2.

Read swap (synchronized rising edge):
- If rdy_valid: rd_idx <= rdy_idx, rdy_idx <= old rd_idx, rdy_valid <= 0.
- Otherwise: indices unchanged and repeat_cnt increments.
- In both cases rd_frame_done pulses for one cycle, coinciding with the updated rd_base_addr.

Simultaneous accepted wr_frame_done and VSYNC edge:
- The just-finished frame goes straight to the reader: rd_idx <= old wr_idx.
- wr_idx <= old rdy_idx; rdy_idx <= old rd_idx; rdy_valid <= 0.
- drop_cnt increments if rdy_valid was 1; repeat_cnt is not incremented.

General rules:
- Counters saturate at all-ones.
- Invariant: wr_idx, rd_idx and rdy_idx are always a permutation of {0,1,2}.
- rd_base_addr changes only in the rd_frame_done cycle. wr_base_addr changes only on an accepted wr_frame_done.
- Reset mid-frame returns to the reset state immediately; external masters must also be reset.

Decomposition:
- Shared package fb_pkg: buffer-index type (2 bits), constant NUM_BUF=3, W_IDLE/W_ACTIVE state encodings, and the default BASE_ADDR and FRAME_STRIDE values shared with the writer and reader.
- One sub-module, vsync_edge_sync: 2-flop synchronizer with reset-to-1 flops and a 1-cycle rising-edge pulse output.

Test Plan:
- Reset -> wr_base_addr=0x0100_0000, rd_base_addr=0x0104_0000, counters 0, rd_frame_done=0.
- wr_frame_start, wr_frame_done, then a VSYNC rise -> wr_base_addr=0x0108_0000 the cycle after done; rd_base_addr=0x0100_0000 with a 1-cycle rd_frame_done exactly 3 clocks after the async rise.
- Two VSYNC rises with no completed frame -> rd_base_addr unchanged, two rd_frame_done pulses, repeat_cnt=2.
- Three write frames between VSYNCs -> drop_cnt=2; the next VSYNC displays the third frame's buffer; invariant holds every cycle.
- wr_frame_done and synchronized edge in the same cycle (rdy_valid=0) -> rd_idx=old wr_idx, rdy_valid=0, both counters unchanged.
- VSYNC held high through reset release -> no rd_frame_done; wr_frame_done in W_IDLE -> no swap; drop_cnt forced to 0xFFFF saturates.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the triple-buffered DDR frame store: buffer indices,
// writer FSM states and the default frame placement used by writer and reader.
package fb_pkg;

  typedef logic [1:0] buf_idx_t;

  localparam int unsigned NUM_BUF = 3;

  typedef enum logic {
    W_IDLE   = 1'b0,
    W_ACTIVE = 1'b1
  } wr_state_t;

  localparam logic [31:0] FB_BASE_ADDR    = 32'h0100_0000;
  localparam logic [31:0] FB_FRAME_STRIDE = 32'h0004_0000;

endpackage

// File: rtl/vsync_edge_sync.sv
// Brings the pixel-domain VSYNC level into the AXI clock domain and emits a
// one-cycle pulse on its synchronized rising edge.
module vsync_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // All stages reset high so a VSYNC already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/frame_buffer_manager.sv
// Triple-buffer scheduler: hands the camera writer and HDMI reader separate DDR
// frame buffers and swaps them only at frame boundaries so the display never tears.
module frame_buffer_manager
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDR    = FB_BASE_ADDR,
  parameter logic [31:0] FRAME_STRIDE = FB_FRAME_STRIDE,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk_100Mhz,
  input  logic                  rst,
  input  logic                  wr_frame_start,
  input  logic                  wr_frame_done,
  output logic [ADDR_WIDTH-1:0] wr_base_addr,
  output logic                  wr_active,
  input  logic                  rd_vsync_async,
  output logic                  rd_frame_done,
  output logic [ADDR_WIDTH-1:0] rd_base_addr,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  repeat_cnt
);

  localparam logic [ADDR_WIDTH-1:0] ADDR0 = ADDR_WIDTH'(64'(BASE_ADDR));
  localparam logic [ADDR_WIDTH-1:0] ADDR1 = ADDR_WIDTH'(64'(BASE_ADDR) + 64'(FRAME_STRIDE));
  localparam logic [ADDR_WIDTH-1:0] ADDR2 =
    ADDR_WIDTH'(64'(BASE_ADDR) + 64'(FRAME_STRIDE) + 64'(FRAME_STRIDE));
  localparam buf_idx_t LAST_IDX = buf_idx_t'(NUM_BUF - 1);

  function automatic logic [ADDR_WIDTH-1:0] base_of(input buf_idx_t idx);
    case (idx)
      buf_idx_t'(1): return ADDR1;
      LAST_IDX:      return ADDR2;
      default:       return ADDR0;
    endcase
  endfunction

  wr_state_t state;
  buf_idx_t  wr_idx, rd_idx, rdy_idx;
  buf_idx_t  wr_idx_n, rd_idx_n, rdy_idx_n;
  logic      rdy_valid, rdy_valid_n;
  logic      vs_rise;
  logic      wr_swap;

  vsync_edge_sync u_vsync (
    .clk      (clk_100Mhz),
    .rst      (rst),
    .async_in (rd_vsync_async),
    .rise     (vs_rise)
  );

  assign wr_swap = (state == W_ACTIVE) && wr_frame_done;

  // Buffer rotation; a simultaneous write swap and VSYNC hands the fresh frame
  // straight to the reader, and the reader's old buffer becomes the spare.
  always_comb begin
    wr_idx_n    = wr_idx;
    rd_idx_n    = rd_idx;
    rdy_idx_n   = rdy_idx;
    rdy_valid_n = rdy_valid;
    if (wr_swap && vs_rise) begin
      rd_idx_n    = wr_idx;
      wr_idx_n    = rdy_idx;
      rdy_idx_n   = rd_idx;
      rdy_valid_n = 1'b0;
    end else if (wr_swap) begin
      rdy_idx_n   = wr_idx;
      wr_idx_n    = rdy_idx;
      rdy_valid_n = 1'b1;
    end else if (vs_rise && rdy_valid) begin
      rd_idx_n    = rdy_idx;
      rdy_idx_n   = rd_idx;
      rdy_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      state         <= W_IDLE;
      wr_active     <= 1'b0;
      wr_idx        <= buf_idx_t'(0);
      rd_idx        <= buf_idx_t'(1);
      rdy_idx       <= buf_idx_t'(2);
      rdy_valid     <= 1'b0;
      wr_base_addr  <= ADDR0;
      rd_base_addr  <= ADDR1;
      rd_frame_done <= 1'b0;
      drop_cnt      <= '0;
      repeat_cnt    <= '0;
    end else begin
      case (state)
        W_IDLE: begin
          if (wr_frame_start) begin
            state     <= W_ACTIVE;
            wr_active <= 1'b1;
          end
        end
        W_ACTIVE: begin
          if (wr_frame_done) begin
            state     <= W_IDLE;
            wr_active <= 1'b0;
          end
        end
        default: begin
          state     <= W_IDLE;
          wr_active <= 1'b0;
        end
      endcase

      wr_idx        <= wr_idx_n;
      rd_idx        <= rd_idx_n;
      rdy_idx       <= rdy_idx_n;
      rdy_valid     <= rdy_valid_n;
      wr_base_addr  <= base_of(wr_idx_n);
      rd_base_addr  <= base_of(rd_idx_n);
      rd_frame_done <= vs_rise;

      if (wr_swap && rdy_valid && (drop_cnt != '1))
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      if (vs_rise && !wr_swap && !rdy_valid && (repeat_cnt != '1))
        repeat_cnt <= repeat_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
